// File: rtl/fft_r22sdf_twiddle_mult.sv
// fft_r22sdf_twiddle_mult: R2^2SDF twiddle stage, x * W_N^e with a 4-cycle pipeline and saturation.
// Define FFT_TWIDDLE_ROUND_EN for round-half-up scaling; default is floor truncation.
module fft_r22sdf_twiddle_mult #(
   parameter int N          = 64,
   parameter int DATA_WIDTH = 25,
   parameter int TW_WIDTH   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_n,
   input  logic                         valid_i,
   input  logic signed [DATA_WIDTH-1:0] x_re_i,
   input  logic signed [DATA_WIDTH-1:0] x_im_i,
   output logic                         valid_o,
   output logic signed [DATA_WIDTH-1:0] z_re_o,
   output logic signed [DATA_WIDTH-1:0] z_im_o,
   output logic                         start_o
);
   localparam int L  = $clog2(N);
   localparam int PW = DATA_WIDTH + TW_WIDTH;
   localparam int W  = PW + 1;
   localparam int SH = TW_WIDTH - 2;
`ifdef FFT_TWIDDLE_ROUND_EN
   localparam logic signed [W-1:0] RND = W'(2 ** (TW_WIDTH - 3));
`else
   localparam logic signed [W-1:0] RND = '0;
`endif

   logic signed [TW_WIDTH-1:0] cos_tab [N];
   logic signed [TW_WIDTH-1:0] sin_tab [N];

   // Twiddle table built at elaboration, rounded to nearest integer
   for (genvar g = 0; g < N; g++) begin : g_rom
      localparam real ang = 6.283185307179586 * g / N;
      localparam real cr  = (2.0 ** SH) * $cos(ang);
      localparam real sr  = (2.0 ** SH) * $sin(ang);
      localparam int  ci  = cr >= 0.0 ? $rtoi(cr + 0.5) : -$rtoi(0.5 - cr);
      localparam int  si  = sr >= 0.0 ? $rtoi(sr + 0.5) : -$rtoi(0.5 - sr);
      assign cos_tab[g] = TW_WIDTH'(ci);
      assign sin_tab[g] = TW_WIDTH'(si);
   end

   logic [L-1:0] n, e;
   logic v1, v2, v3, st1, st2, st3;
   logic signed [DATA_WIDTH-1:0] xr1, xi1;
   logic signed [TW_WIDTH-1:0] c1, s1;
   logic signed [PW-1:0] prc, pis, pic, prs;
   logic signed [W-1:0] re3, im3, re_sh, im_sh;

   // e = n2 * bitrev(n1); never exceeds N-1
   assign e     = L'(n[L-3:0]) * L'({n[L-2], n[L-1]});
   assign re_sh = re3 >>> SH;
   assign im_sh = im3 >>> SH;

   function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [W-1:0] v);
      return (&v[W-1:DATA_WIDTH-1] || ~|v[W-1:DATA_WIDTH-1]) ? v[DATA_WIDTH-1:0]
             : {v[W-1], {(DATA_WIDTH-1){~v[W-1]}}};
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         n       <= '0;
         {v1, v2, v3, st1, st2, st3} <= '0;
         valid_o <= 1'b0;
         start_o <= 1'b0;
         z_re_o  <= '0;
         z_im_o  <= '0;
      end else begin
         n       <= n + L'(valid_i);
         v1      <= valid_i;
         st1     <= valid_i && n == '0;
         v2      <= v1;
         st2     <= st1;
         v3      <= v2;
         st3     <= st2;
         valid_o <= v3;
         start_o <= st3;
         z_re_o  <= sat(re_sh);
         z_im_o  <= sat(im_sh);
      end
   end

   always_ff @(posedge clk_i) begin
      xr1 <= x_re_i;
      xi1 <= x_im_i;
      c1  <= cos_tab[e];
      s1  <= sin_tab[e];
      prc <= PW'(xr1) * PW'(c1);
      pis <= PW'(xi1) * PW'(s1);
      pic <= PW'(xi1) * PW'(c1);
      prs <= PW'(xr1) * PW'(s1);
      re3 <= W'(prc) + W'(pis) + RND;
      im3 <= W'(pic) - W'(prs) + RND;
   end
endmodule

// File: tb/tb_fft_r22sdf_twiddle_mult.sv
// tb_fft_r22sdf_twiddle_mult: randomized scoreboard bench for the twiddle stage (N=16).
// Follows FFT_TWIDDLE_ROUND_EN the same way as the design.
module tb_fft_r22sdf_twiddle_mult;
   localparam int N  = 16;
   localparam int DW = 25;
   localparam int TW = 16;
   localparam int SH = TW - 2;

   logic clk_i = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
   logic signed [DW-1:0] x_re_i = '0, x_im_i = '0;
   logic valid_o, start_o;
   logic signed [DW-1:0] z_re_o, z_im_o;

   fft_r22sdf_twiddle_mult #(.N(N), .DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .x_re_i(x_re_i), .x_im_i(x_im_i),
      .valid_o(valid_o), .z_re_o(z_re_o), .z_im_o(z_im_o), .start_o(start_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {longint re; longint im; bit st; int due;} exp_t;
   exp_t q[$];
   exp_t m;
   int cyc = 0, vectors = 0, errs = 0, n_mod = 0;
   bit rst_q = 1'b1;
   longint ctab[N], stab[N];
   int br[4] = '{0, 2, 1, 3};

   always @(posedge clk_i) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   function automatic longint scale(input longint p);
      longint v;
`ifdef FFT_TWIDDLE_ROUND_EN
      v = (p + (longint'(1) << (SH - 1))) >>> SH;
`else
      v = p >>> SH;
`endif
      if (v > (longint'(1) << (DW - 1)) - 1) v = (longint'(1) << (DW - 1)) - 1;
      if (v < -(longint'(1) << (DW - 1))) v = -(longint'(1) << (DW - 1));
      return v;
   endfunction

   function automatic logic signed [DW-1:0] rnd_x();
      return DW'($urandom);
   endfunction

   // Issue one sample; if accepted, predict its output from the frame position
   task automatic send(input logic signed [DW-1:0] xr, input logic signed [DW-1:0] xi);
      exp_t x;
      int e;
      valid_i = 1'b1;
      x_re_i  = xr;
      x_im_i  = xi;
      if (rst_n) begin
         e    = (n_mod % 4) * br[n_mod / 4];
         x.re = scale(longint'(xr) * ctab[e] + longint'(xi) * stab[e]);
         x.im = scale(longint'(xi) * ctab[e] - longint'(xr) * stab[e]);
         x.st = (n_mod == 0);
         x.due = cyc + 4;
         q.push_back(x);
         n_mod = (n_mod + 1) % N;
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk_i); #1; end
   endtask

   task automatic do_reset(input int k);
      rst_n = 1'b0;
      for (int i = 0; i < k; i++) begin
         valid_i = 1'($urandom);
         x_re_i  = rnd_x();
         x_im_i  = rnd_x();
         @(posedge clk_i); #1;
         if (i == 0) q.delete();
      end
      n_mod   = 0;
      rst_n   = 1'b1;
      valid_i = 1'b0;
   endtask

   always @(negedge clk_i) begin
      if (!rst_q) begin
         vectors++;
         if (valid_o !== 1'b0 || start_o !== 1'b0 || z_re_o !== '0 || z_im_o !== '0) begin
            errs++;
            $display("FAIL reset_state cyc=%0d got valid=%b start=%b re=%0d im=%0d, want all zero",
                     cyc, valid_o, start_o, z_re_o, z_im_o);
         end
      end else if (valid_o === 1'b1) begin
         vectors++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_valid cyc=%0d got re=%0d im=%0d, want no output", cyc, z_re_o, z_im_o);
         end else begin
            m = q.pop_front();
            if (longint'(z_re_o) !== m.re || longint'(z_im_o) !== m.im || start_o !== m.st || cyc != m.due) begin
               errs++;
               $display("FAIL sample cyc=%0d got re=%0d im=%0d start=%b, want re=%0d im=%0d start=%b at cyc=%0d",
                        cyc, z_re_o, z_im_o, start_o, m.re, m.im, m.st, m.due);
            end
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         vectors++;
         errs++;
         m = q.pop_front();
         $display("FAIL missing_output cyc=%0d got valid=%b, want re=%0d im=%0d at cyc=%0d",
                  cyc, valid_o, m.re, m.im, m.due);
      end
   end

   initial begin
      for (int e = 0; e < N; e++) begin
         ctab[e] = longint'($rtoi($floor(16384.0 * $cos(6.283185307179586 * e / N) + 0.5)));
         stab[e] = longint'($rtoi($floor(16384.0 * $sin(6.283185307179586 * e / N) + 0.5)));
      end
      do_reset(5);
      idle(2);
      for (int k = 0; k < 16; k++) send(DW'(1000 + k), -25'sd500);
      for (int k = 0; k < 16; k++)
         if (k == 5) send(25'sd1000, 25'sd0);
         else if (k == 9) send(25'sd0, 25'sd1000);
         else send(rnd_x(), rnd_x());
      for (int k = 0; k < 16; k++)
         if (k == 5) send(25'sd16777215, 25'sd16777215);
         else send(rnd_x(), rnd_x());
      for (int k = 0; k < 16; k++)
         if (k == 5) send(-25'sd16777216, -25'sd16777216);
         else send(rnd_x(), rnd_x());
      for (int k = 0; k < 20; k++) begin
         send(rnd_x(), rnd_x());
         idle(2);
      end
      idle(6);
      do_reset(1);
      for (int k = 0; k < 8; k++) send(rnd_x(), rnd_x());
      do_reset(2);
      for (int k = 0; k < 6; k++) send(rnd_x(), rnd_x());
      for (int k = 0; k < 48; k++) begin
         if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
         send(rnd_x(), rnd_x());
      end
      idle(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
